chunked_adder: RTL
==================

# chunked_adder

Parametrised multi-cycle binary adder. Adds two WIDTH-bit operands CHUNK bits per clock, keeping the carry in a register between chunks. It produces a WIDTH+1-bit sum. Valid/ready handshakes on input and output let it sit between pipeline stages in the datapath. It succeeds the fixed 4-bit combinational adder where wide operands would make a single-cycle ripple path too long.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- sub  in  1  1 = compute a − b. Present only with ADDER_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH+1  result; bit WIDTH is the final carry-out.

## Operation
- NCHUNK = WIDTH/CHUNK. Chunk index register is $clog2(NCHUNK) bits, minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch a and b (b inverted if subtracting), set carry=0 (1 if subtracting), idx=0, go to RUN.
- RUN:
  - Each cycle: {c, s} = a[idx] + b[idx] + carry, where a[idx]/b[idx] are CHUNK-bit slices.
  - Write s to sum[idx*CHUNK +: CHUNK], store c in carry, increment idx.
  - When idx == NCHUNK−1, write c to sum[WIDTH] and go to DONE.
- DONE:
  - out_valid=1; sum is held stable.
  - On out_ready, go to IDLE.
- in_ready is low in RUN and DONE. in_valid during those states is ignored; nothing is latched.
- Width rule: sum = a + b modulo 2^(WIDTH+1). No truncation.
- sum holds its last result in IDLE. Consumers sample sum only while out_valid=1.
- Reset (any state, including mid-RUN): abort immediately.
  - Next state IDLE; in_ready=1 while rst_n is low.
  - out_valid=0, sum=0, carry=0, idx=0.
  - A partial result is never presented.

## Timing
- Accept edge T (in_valid & in_ready).
- Chunks are computed on edges T+1 … T+NCHUNK.
- out_valid is high after edge T+NCHUNK.
- Latency is NCHUNK cycles from accept to out_valid.
- If out_ready is already high, the result handshake completes at edge T+NCHUNK+1 and in_ready rises after it.
- Peak throughput: one operation per NCHUNK+2 cycles.
- CHUNK == WIDTH: a single RUN cycle; latency 1.
- out_ready may be high before out_valid; it has no effect until DONE.
- All outputs are registered or decoded from state only. There are no combinational input-to-output paths.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists and is latched with the operands.
  - With sub=1: b is stored inverted and carry is initialised to 1, so sum[WIDTH−1:0] = a − b mod 2^WIDTH.
  - sum[WIDTH] = 1 means no borrow (a ≥ b).
- ADDER_SUB_EN undefined:
  - No sub port; add only.
  - The inversion logic is absent.

## Structure
- Package chunked_adder_pkg:
  - state typedef enum {IDLE, RUN, DONE}.
  - localparam helpers for NCHUNK and index width.
- Sub-module chunk_add: combinational CHUNK-bit adder.
  - Inputs: x, y, cin. Outputs: s, cout.
  - Instantiated once and shared across all chunk cycles.

## Test plan
- WIDTH=16, CHUNK=4, a=0x1234, b=0x4321 → sum=0x05555; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001 → sum=0x10000; the carry ripples through all 4 chunks.
- WIDTH=4, CHUNK=1, a=9, b=9 → sum=5'b10010; latency 4. Also a=0, b=0 → sum=0.
- Backpressure: out_ready held low for 10 cycles after out_valid.
  - sum stays 0x05555 throughout; in_ready stays 0.
  - in_valid pulsed during this time with new operands is ignored.
  - When out_ready rises, in_ready returns 1 the next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 chunks.
  - Immediately: out_valid=0, sum=0, in_ready=1.
  - A new operation after release completes correctly.
- With ADDER_SUB_EN defined:
  - a=0x0005, b=0x0007, sub=1 → sum[15:0]=0xFFFE, sum[16]=0.
  - a=0x0007, b=0x0005, sub=1 → sum=0x10002.

Source files
------------

// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked multi-cycle adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk adder still carries a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder; `sub` exists only when
// ADDER_SUB_EN is defined.
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  modport master (
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/chunked_adder_chunk_add.sv
// Combinational CHUNK-bit adder with carry in/out, shared across all chunk cycles.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock.
// Optional subtract mode enabled by defining ADDER_SUB_EN.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_adder_if.slave  bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH:0]   sum_reg;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic [CHUNK-1:0] x_sel, y_sel, chunk_s;
  logic             chunk_cout;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign x_sel = a_chunks[idx_reg];
  assign y_sel = b_chunks[idx_reg];
  assign last  = (idx_reg == IW'(NCHUNK - 1));

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .x    (x_sel),
    .y    (y_sel),
    .cin  (carry_reg),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  // Subtraction is a + ~b + 1: invert b at load and seed the carry.
`ifdef ADDER_SUB_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub;
`else
  assign b_load     = bus.b;
  assign carry_load = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (last)          state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && bus.in_valid) begin
        a_reg     <= bus.a;
        b_reg     <= b_load;
        carry_reg <= carry_load;
        idx_reg   <= '0;
      end else if (state_reg == RUN) begin
        sum_reg[int'(idx_reg)*CHUNK +: CHUNK] <= chunk_s;
        carry_reg <= chunk_cout;
        idx_reg   <= idx_reg + IW'(1);
        if (last) sum_reg[WIDTH] <= chunk_cout;
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
endmodule
